rsff_1: RTL and testbench

Clocked RS (set/reset) flip-flop bank with synchronous, active-high reset and a configurable policy for the forbidden `r = s = 1` input. It serves as a generic single-bit or multi-bit state-holding primitive in control paths where set/clear requests arrive as independent level signals. All state changes occur on the rising edge of `clk`.

---
 rtl/rsff_pkg.sv | 33 +++
 rtl/rsff_cell.sv | 44 ++++
 rtl/rsff_1.sv | 44 ++++
 tb/tb_rsff_1.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/rsff_pkg.sv
// Shared policy encodings and next-state helper for the RS flip-flop bank.
// Imported by the cell and the top level.
package rsff_pkg;

  typedef logic [1:0] sr_policy_t;

  localparam sr_policy_t SR_RESET_DOM = 2'd0;
  localparam sr_policy_t SR_SET_DOM   = 2'd1;
  localparam sr_policy_t SR_HOLD      = 2'd2;
  localparam sr_policy_t SR_TOGGLE    = 2'd3;

  // Next state of one cell; the policy only matters when r and s are both high.
  function automatic logic sr_next(input sr_policy_t pol, input logic q,
                                   input logic r, input logic s);
    logic nxt;
    nxt = q;
    case ({r, s})
      2'b00: nxt = q;
      2'b01: nxt = 1'b1;
      2'b10: nxt = 1'b0;
      default: begin
        case (pol)
          SR_RESET_DOM: nxt = 1'b0;
          SR_SET_DOM:   nxt = 1'b1;
          SR_HOLD:      nxt = q;
          default:      nxt = ~q;
        endcase
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rsff_cell.sv
// Single-bit clocked RS cell with a registered complement and conflict flag.
// All outputs come straight from flops; nothing is derived combinationally from inputs.
module rsff_cell
  import rsff_pkg::*;
#(
  parameter int SR_POLICY = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic r,
  input  logic s,
  output logic q,
  output logic qn,
  output logic conflict
);

  localparam sr_policy_t POL = sr_policy_t'(SR_POLICY);

  // Power-up values give a deterministic simulation start before any reset.
  logic r_q        = 1'b0;
  logic r_qn       = 1'b1;
  logic r_conflict = 1'b0;
  logic w_q_next;

  assign w_q_next = sr_next(POL, r_q, r, s);

  // An undriven or unknown rst falls through to the else branch, so the cell keeps working.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= 1'b0;
      r_qn       <= 1'b1;
      r_conflict <= 1'b0;
    end else begin
      r_q        <= w_q_next;
      r_qn       <= ~w_q_next;
      r_conflict <= r & s;
    end
  end

  assign q        = r_q;
  assign qn       = r_qn;
  assign conflict = r_conflict;

endmodule

// File: rtl/rsff_1.sv
// Bank of WIDTH independent RS cells sharing one clock, reset and conflict policy.
// Holds only parameter checks and the per-bit replication.
module rsff_1
  import rsff_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int SR_POLICY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] conflict
);

  generate
    if (SR_POLICY < 0 || SR_POLICY > 3) begin : g_bad_policy
      $error("rsff_1: SR_POLICY must be 0..3");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("rsff_1: WIDTH must be at least 1");
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      rsff_cell #(
        .SR_POLICY(SR_POLICY)
      ) u_cell (
        .clk      (clk),
        .rst      (rst),
        .r        (r[gi]),
        .s        (s[gi]),
        .q        (q[gi]),
        .qn       (qn[gi]),
        .conflict (conflict[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_rsff_1.sv
// Scoreboard bench: one WIDTH=1 default instance plus WIDTH=4 instances for all four policies.
// Stimulus pushes hand-computed expectations; a monitor pops and compares after each edge.
module tb_rsff_1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] r;
  logic [3:0] s;

  logic       q1, qn1, cf1;
  logic [3:0] q_p  [4];
  logic [3:0] qn_p [4];
  logic [3:0] cf_p [4];

  always #50 clk = ~clk;

  rsff_1 u_w1 (
    .clk      (clk),
    .rst      (rst),
    .r        (r[0]),
    .s        (s[0]),
    .q        (q1),
    .qn       (qn1),
    .conflict (cf1)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pol
      rsff_1 #(
        .WIDTH     (4),
        .SR_POLICY (gi)
      ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .r        (r),
        .s        (s),
        .q        (q_p[gi]),
        .qn       (qn_p[gi]),
        .conflict (cf_p[gi])
      );
    end
  endgenerate

  // rstm: 0 = low, 1 = high, 2 = unknown (stands in for an unconnected reset)
  typedef struct packed {
    logic [1:0]  rstm;
    logic [3:0]  r;
    logic [3:0]  s;
    logic [15:0] q;    // {policy3, policy2, policy1, policy0}
    logic [3:0]  cf;
  } vec_t;

  typedef struct packed {
    logic [15:0] q;
    logic [3:0]  cf;
  } exp_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC] = '{
    '{2'd2, 4'hF, 4'h0, 16'h0000, 4'h0},
    '{2'd2, 4'h0, 4'h0, 16'h0000, 4'h0},
    '{2'd2, 4'h0, 4'hF, 16'hFFFF, 4'h0},
    '{2'd2, 4'h0, 4'h0, 16'hFFFF, 4'h0},
    '{2'd1, 4'h0, 4'hF, 16'h0000, 4'h0},
    '{2'd0, 4'h0, 4'hF, 16'hFFFF, 4'h0},
    '{2'd0, 4'hF, 4'hF, 16'h0FF0, 4'hF},
    '{2'd0, 4'hF, 4'hF, 16'hFFF0, 4'hF},
    '{2'd0, 4'h0, 4'h0, 16'hFFF0, 4'h0},
    '{2'd1, 4'hF, 4'hF, 16'h0000, 4'h0},
    '{2'd0, 4'h5, 4'hA, 16'hAAAA, 4'h0},
    '{2'd0, 4'h8, 4'h0, 16'h2222, 4'h0},
    '{2'd0, 4'hC, 4'hA, 16'hA2A2, 4'h8},
    '{2'd0, 4'hC, 4'hA, 16'h22A2, 4'h8},
    '{2'd0, 4'h0, 4'h0, 16'h22A2, 4'h0},
    '{2'd0, 4'hF, 4'hF, 16'hD2F0, 4'hF}
  };

  exp_t sb [$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int idx, input logic [3:0] act,
                     input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] t=%0t got %b expected %b", name, idx, $time, act, exp);
    end
  endtask

  task automatic check_all(input string phase, input exp_t e);
    logic [3:0] qe;
    for (int p = 0; p < 4; p++) begin
      qe = e.q[p*4 +: 4];
      chk({phase, "_q"},  p, q_p[p],  qe);
      chk({phase, "_qn"}, p, qn_p[p], ~qe);
      chk({phase, "_cf"}, p, cf_p[p], e.cf);
    end
    chk({phase, "_w1_q"},  0, {3'b000, q1},  {3'b000, e.q[0]});
    chk({phase, "_w1_qn"}, 0, {3'b000, qn1}, {3'b000, ~e.q[0]});
    chk({phase, "_w1_cf"}, 0, {3'b000, cf1}, {3'b000, e.cf[0]});
  endtask

  // Monitor: compare right after each edge, then again mid-glitch of the next period.
  initial begin : monitor
    exp_t cur;
    bit   have;
    have = 1'b0;
    cur  = '0;
    forever begin
      @(posedge clk);
      #20;
      if (sb.size() > 0) begin
        cur  = sb.pop_front();
        have = 1'b1;
        check_all("edge", cur);
      end
      #55;
      if (have) check_all("hold", cur);
    end
  end

  initial begin : stim
    logic       rst_save;
    logic [3:0] s_save;
    exp_t       e;
    rst = 1'bx;
    r   = 4'h0;
    s   = 4'h0;
    for (int k = 0; k < NVEC; k++) begin
      case (vecs[k].rstm)
        2'd0:    rst = 1'b0;
        2'd1:    rst = 1'b1;
        default: rst = 1'bx;
      endcase
      r = vecs[k].r;
      s = vecs[k].s;
      e.q  = vecs[k].q;
      e.cf = vecs[k].cf;
      sb.push_back(e);
      #10;
      // Glitch s and rst well away from the edge; outputs must not move.
      rst_save = rst;
      s_save   = s;
      s   = ~s;
      rst = 1'b1;
      #20;
      s   = s_save;
      rst = rst_save;
      #70;
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #100;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
